// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Framed byte-stream boot loader. Assembles little-endian words
//               into the unified memory and holds the CPU in reset until done.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [7:0] c_magic     = 8'hA5;
    localparam logic [7:0] c_max_words = 8'(MAX_WORDS);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len;
    logic [7:0]        r_word_idx;
    logic [7:0]        r_word_count;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;      // lanes 0..2; lane 3 is merged on the final byte
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_accept;
    logic              w_len_bad;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_addr;

    assign w_accept    = rx_valid & rx_ready;
    assign w_len_bad   = (rx_data == 8'd0) || (rx_data > c_max_words);
    assign w_last_word = ((r_word_idx + 8'd1) == r_len);
    assign w_addr      = ADDR_W'({r_word_idx, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && (rx_data == c_magic)) w_next = S_HDR;
            S_HDR:   if (w_accept) w_next = w_len_bad ? S_ERR : S_DATA;
            S_DATA:  if (w_accept && (r_byte_idx == 2'd3)) w_next = S_WRITE;
            S_WRITE: w_next = w_last_word ? S_DONE : S_DATA;
            S_DONE:  w_next = S_DONE;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // The write address/data are captured with the 4th byte so they are
    // already stable in WRITE and keep their value afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len        <= 8'd0;
            r_word_idx   <= 8'd0;
            r_word_count <= 8'd0;
            r_byte_idx   <= 2'd0;
            r_word       <= 24'd0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        r_len      <= rx_data;
                        r_byte_idx <= 2'd0;
                        r_word_idx <= 8'd0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0:    r_word[7:0]   <= rx_data;
                            2'd1:    r_word[15:8]  <= rx_data;
                            2'd2:    r_word[23:16] <= rx_data;
                            default: begin
                                r_mem_addr  <= w_addr;
                                r_mem_wdata <= {rx_data, r_word};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_word_count <= r_word_count + 8'd1;
                    if (!w_last_word) r_word_idx <= r_word_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign rx_ready   = (r_state == S_IDLE) || (r_state == S_HDR) || (r_state == S_DATA);
    assign mem_we     = (r_state == S_WRITE);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_rst    = (r_state != S_DONE);
    assign load_done  = (r_state == S_DONE);
    assign load_err   = (r_state == S_ERR);
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Scoreboard bench for program_loader with randomized framing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;
    logic [7:0]        word_count;

    program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    int                exp_cyc_q[$];
    logic [7:0]        frame[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                check("write_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                check("write_data", mem_wdata, exp_data_q.pop_front());
                if (exp_cyc_q.size() != 0)
                    check("write_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                else
                    check("write_latency_missing", 32'(cyc), 32'hFFFF_FFFF);
            end
        end
        if (!rst && !load_done && !load_err)
            check("rx_ready_vs_write", 32'(rx_ready), 32'(!mem_we));
    end

    task automatic send_byte(input logic [7:0] b, input int gapmax,
                             output bit accepted, output int acc_cyc);
        int n = 0;
        accepted = 1'b0;
        acc_cyc  = 0;
        repeat ($urandom_range(gapmax, 0)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accepted = 1'b1;
        acc_cyc  = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Reference model: parse the frame from the byte rules, queue expected
    // writes, then drive bytes; returns the number of words expected written.
    task automatic run_frame(input int limit, input int gapmax, output int n_words, output bit ok);
        int  m = -1;
        int  n = -1;
        bit  acc;
        int  acyc;
        for (int i = 0; i < frame.size(); i++)
            if (frame[i] == 8'hA5) begin m = i; break; end
        if (m >= 0 && m + 1 < frame.size()) n = int'(frame[m+1]);
        ok = (n >= 1) && (n <= MAX_WORDS);
        n_words = 0;
        if (ok) begin
            for (int w = 0; w < n; w++) begin
                int b = m + 2 + 4 * w;
                if (b + 3 < limit) begin
                    exp_addr_q.push_back(ADDR_W'(w * 4));
                    exp_data_q.push_back({frame[b+3], frame[b+2], frame[b+1], frame[b]});
                    n_words++;
                end
            end
        end
        for (int k = 0; k < limit && k < frame.size(); k++) begin
            send_byte(frame[k], gapmax, acc, acyc);
            if (!acc) break;
            if (ok && k >= m + 2 && ((k - m - 2) % 4) == 3) exp_cyc_q.push_back(acyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_cyc_q.delete();
        check("rst_rx_ready",   32'(rx_ready),   32'd1);
        check("rst_cpu_rst",    32'(cpu_rst),    32'd1);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_load_done",  32'(load_done),  32'd0);
        check("rst_load_err",   32'(load_err),   32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
    endtask

    // Called at the negedge of the final WRITE cycle.
    task automatic finish_ok(input int n);
        check("last_write_strobe", 32'(mem_we),  32'd1);
        check("cpu_rst_in_write",  32'(cpu_rst), 32'd1);
        @(negedge clk);
        check("done_cpu_rst",    32'(cpu_rst),    32'd0);
        check("done_load_done",  32'(load_done),  32'd1);
        check("done_load_err",   32'(load_err),   32'd0);
        check("done_rx_ready",   32'(rx_ready),   32'd0);
        check("done_word_count", 32'(word_count), 32'(n));
        check("done_pending",    32'(exp_addr_q.size()), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        check("done_ignores_rx", 32'(word_count), 32'(n));
        check("done_held",       32'(load_done),  32'd1);
    endtask

    task automatic finish_err();
        check("err_load_err",   32'(load_err),   32'd1);
        check("err_rx_ready",   32'(rx_ready),   32'd0);
        check("err_cpu_rst",    32'(cpu_rst),    32'd1);
        check("err_load_done",  32'(load_done),  32'd0);
        check("err_word_count", 32'(word_count), 32'd0);
        repeat (3) @(negedge clk);
        check("err_sticky",     32'(load_err),   32'd1);
    endtask

    task automatic run_and_finish(input int gapmax);
        int  nw;
        bit  ok;
        run_frame(frame.size(), gapmax, nw, ok);
        if (ok) finish_ok(nw);
        else    finish_err();
    endtask

    initial begin
        int nw;
        bit ok;
        int n;

        do_reset();

        frame = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_and_finish(0);
        do_reset();

        frame = '{8'h5A, 8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_and_finish(0);
        do_reset();

        frame = '{8'hA5, 8'h00};
        run_and_finish(0);
        do_reset();
        frame = '{8'hA5, 8'h41};
        run_and_finish(0);
        do_reset();

        frame = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_and_finish(7);
        do_reset();

        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(8'h02);
        for (int i = 0; i < 8; i++) frame.push_back(8'($urandom));
        run_frame(8, 0, nw, ok);
        repeat (3) @(negedge clk);
        check("abort_word_count", 32'(word_count), 32'd1);
        check("abort_cpu_rst",    32'(cpu_rst),    32'd1);
        do_reset();

        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(8'd64);
        for (int i = 0; i < 256; i++) frame.push_back(8'($urandom));
        run_and_finish(0);
        check("max_last_addr", 32'(mem_addr), 32'h0000_00FC);
        do_reset();

        for (int it = 0; it < 8; it++) begin
            frame.delete();
            repeat ($urandom_range(2, 0)) frame.push_back(8'($urandom_range(8'hA4, 0)));
            frame.push_back(8'hA5);
            if ($urandom_range(3, 0) == 0)
                n = ($urandom_range(1, 0) == 0) ? 0 : 65 + int'($urandom_range(190, 0));
            else
                n = int'($urandom_range(8, 1));
            frame.push_back(8'(n));
            if (n >= 1 && n <= MAX_WORDS)
                for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
            run_and_finish(int'($urandom_range(3, 0)));
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
